dark_min_filter: RTL
====================

DARK_MIN_FILTER -- requirements
Module: dark_min_filter

Interface
REQ-001 SHALL have parameter: IMG_W, 640, pixels per line (≥4).
REQ-002 SHALL have parameter: IMG_H, 480, lines per frame (≥3).
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: dark  input  8  per-pixel dark-channel value (min of R,G,B) from the upstream stage.
REQ-006 SHALL have port: vsync  input  1  frame sync; a rising edge marks start of frame.
REQ-007 SHALL have port: en  input  1  dark valid this cycle, raster order.
REQ-008 SHALL have port: o_dark  output  8  3x3-eroded dark value.
REQ-009 SHALL have port: o_en  output  1  o_dark valid.
REQ-010 SHALL have port: o_hsync  output  1  one-cycle pulse with the first valid pixel of each output line.
REQ-011 SHALL have port: o_vsync  output  1  one-cycle pulse with output pixel (0,0).
REQ-012 SHALL have port: o_frame_done  output  1  one-cycle pulse the cycle after the last output pixel of a frame.
REQ-013 SHALL have port: o_err  output  1  sticky; set when en is high during FLUSH or IDLE; cleared only by reset.

Function
REQ-014 SHALL compute o_dark(r,c) = min of dark over rows r-1..r+1 and cols c-1..c+1; positions outside the image SHALL count as 8'hFF.
REQ-015 SHALL store the two previous input lines in two IMG_W x 8 line buffers; column and row counters SHALL wrap at IMG_W and IMG_H.
REQ-016 SHALL implement states IDLE, FILL, RUN and FLUSH.
REQ-017 SHALL leave IDLE for FILL on a vsync rising edge and clear the counters.
REQ-018 SHALL stay in FILL (input row 0) while storing only; o_en SHALL stay low in FILL.
REQ-019 SHALL enter RUN after IMG_W pixels in FILL; input row r+1 in RUN SHALL produce output row r.
REQ-020 SHALL enter FLUSH after the last pixel of row IMG_H-1, then emit output row IMG_H-1 internally at one column per cycle with the bottom row as 8'hFF.
REQ-021 SHALL return to IDLE after FLUSH and pulse o_frame_done.
REQ-022 SHALL treat the cycle right after each line's last pixel as a virtual column IMG_W (all 8'hFF); upstream SHALL leave en low for ≥2 cycles between lines.
REQ-023 SHALL compute the vertical 3-row min in pipe stage 1 and the horizontal 3-column min in stage 2.
REQ-024 SHALL assert o_en for output (r,c) exactly 2 cycles after the cycle in which column c+1 (real or virtual) of input row r+1 is sampled.
REQ-025 SHALL produce one output pixel per input pixel and no output on idle cycles, except for the virtual-column slot.
REQ-026 SHALL, on a vsync rising edge in FILL, RUN or FLUSH, abandon the frame, suppress o_frame_done, flush the pipeline without asserting o_en, and restart in FILL.
REQ-027 SHALL ignore en in IDLE and FLUSH, dropping the data and setting o_err.
REQ-028 SHALL require upstream to hold en low for ≥ IMG_W+4 cycles after the last pixel of a frame.
REQ-029 SHALL use unsigned 8-bit compares; a tie SHALL select either operand (same value).

Reset
REQ-030 SHALL, while nrst=0, drive o_dark=0, o_en=0, o_hsync=0, o_vsync=0, o_frame_done=0 and o_err=0, with state IDLE and counters 0.
REQ-031 SHALL not require line-buffer contents to be reset; FILL overwrites them before any read affects o_dark.
REQ-032 SHALL, on reset mid-frame, emit no output until the next vsync rising edge.

Verification (IMG_W=4, IMG_H=3)
REQ-033 SHALL pass: all pixels 100 -> 12 outputs, all 100, o_vsync once, o_hsync 3 times, o_frame_done once.
REQ-034 SHALL pass: single 5 at (1,1), rest 200 -> outputs at rows 0-2, cols 0-2 = 5; cols 3 = 200.
REQ-035 SHALL pass: 0 at (0,0), rest 255 -> outputs (0,0),(0,1),(1,0),(1,1) = 0; all others 255.
REQ-036 SHALL pass: first pixel (1,1) sampled at cycle T -> o_en for (0,0) high at T+2.
REQ-037 SHALL pass: vsync rising edge after 6 pixels, then a full frame -> outputs only from the second frame, o_frame_done once.
REQ-038 SHALL pass: en high for one cycle during FLUSH -> o_err=1 and stays 1; the frame output is unchanged.

Source files
------------

// File: rtl/dark_min_filter.sv
// 3x3 erosion (minimum) of a raster dark-channel stream, with image borders
// treated as 8'hFF. Two line buffers; vertical min in stage 1, horizontal min in stage 2.
module dark_min_filter #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] dark,
  input  logic       vsync,
  input  logic       en,
  output logic [7:0] o_dark,
  output logic       o_en,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_frame_done,
  output logic       o_err
);

  localparam int AW = $clog2(IMG_W);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_VIRT = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_TOP  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          virt;
  logic          vsync_q;

  logic [7:0]    lb_a [IMG_W];
  logic [7:0]    lb_b [IMG_W];
  logic [AW-1:0] idx;

  logic          sof;
  logic          kill;
  logic          take;

  logic          push;
  logic [7:0]    vmin;
  logic          c0;
  logic          emit;
  logic          hs;
  logic          vs;
  logic          last;

  logic [7:0]    v1, v2, v3;
  logic          s1_v, s1_hs, s1_vs, s1_last;
  logic          s2_last;

  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  assign idx  = col[AW-1:0];
  assign sof  = vsync & ~vsync_q;
  assign kill = sof && (state != IDLE);
  assign take = !sof && en && !virt && ((state == FILL) || (state == RUN));

  // Stage-1 source: virtual FF column, a live RUN pixel, or a FLUSH column
  // re-read from the line buffers with the row below the image as FF.
  always_comb begin
    push = 1'b0;
    vmin = 8'hFF;
    c0   = 1'b0;
    emit = 1'b0;
    hs   = 1'b0;
    vs   = 1'b0;
    last = 1'b0;
    if (virt) begin
      push = 1'b1;
      emit = 1'b1;
    end else if ((state == RUN) && en) begin
      push = 1'b1;
      vmin = min2(min2((row == ROW_TOP) ? 8'hFF : lb_b[idx], lb_a[idx]), dark);
      c0   = (col == '0);
      emit = (col != '0);
      hs   = (col == COL_ONE);
      vs   = (col == COL_ONE) && (row == ROW_TOP);
    end else if (state == FLUSH) begin
      push = 1'b1;
      if (col == COL_VIRT) begin
        emit = 1'b1;
        last = 1'b1;
      end else begin
        vmin = min2(lb_b[idx], lb_a[idx]);
        c0   = (col == '0);
        emit = (col != '0);
        hs   = (col == COL_ONE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      lb_b[idx] <= lb_a[idx];
      lb_a[idx] <= dark;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      virt         <= 1'b0;
      vsync_q      <= 1'b0;
      v1           <= '1;
      v2           <= '1;
      v3           <= '1;
      s1_v         <= 1'b0;
      s1_hs        <= 1'b0;
      s1_vs        <= 1'b0;
      s1_last      <= 1'b0;
      s2_last      <= 1'b0;
      o_dark       <= '0;
      o_en         <= 1'b0;
      o_hsync      <= 1'b0;
      o_vsync      <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      vsync_q <= vsync;
      virt    <= 1'b0;

      if (sof) begin
        state <= FILL;
        col   <= '0;
        row   <= '0;
      end else begin
        unique case (state)
          IDLE: ;
          FILL: begin
            if (en) begin
              if (col == COL_LAST) begin
                col   <= '0;
                row   <= ROW_TOP;
                state <= RUN;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          RUN: begin
            if (en && !virt) begin
              if (col == COL_LAST) begin
                col  <= '0;
                virt <= 1'b1;
                if (row == ROW_LAST) begin
                  row   <= '0;
                  state <= FLUSH;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          FLUSH: begin
            if (!virt) begin
              if (col == COL_VIRT) begin
                col   <= '0;
                state <= IDLE;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (en && ((state == IDLE) || (state == FLUSH)))
        o_err <= 1'b1;

      // Abandoned frame: drop whatever is in flight so no o_en escapes.
      if (kill) begin
        s1_v         <= 1'b0;
        s1_hs        <= 1'b0;
        s1_vs        <= 1'b0;
        s1_last      <= 1'b0;
        s2_last      <= 1'b0;
        o_en         <= 1'b0;
        o_hsync      <= 1'b0;
        o_vsync      <= 1'b0;
        o_frame_done <= 1'b0;
      end else begin
        if (push) begin
          v1 <= vmin;
          v2 <= c0 ? 8'hFF : v1;
          v3 <= c0 ? 8'hFF : v2;
        end
        s1_v    <= push & emit;
        s1_hs   <= push & hs;
        s1_vs   <= push & vs;
        s1_last <= push & last;

        o_en <= s1_v;
        if (s1_v)
          o_dark <= min2(min2(v1, v2), v3);
        o_hsync      <= s1_v & s1_hs;
        o_vsync      <= s1_v & s1_vs;
        s2_last      <= s1_v & s1_last;
        o_frame_done <= s2_last;
      end
    end
  end

endmodule
